vga_bar_ctrl: RTL and testbench

- Frame-synchronous controller that collects per-column segmentation sums from the segmentation datapath over a valid/ready stream.
- Thresholds each sum and double-buffers the resulting six bar-enable flags.
- Swaps the flags into the VGA painter only at the start of vertical sync, so bars never tear mid-frame.
- Sits between the segmentation row-sum logic and the 640x480 bar renderer, on the 25 MHz pixel clock.

---
 rtl/vga_bar_pkg.sv | 28 ++
 rtl/vga_frame_edge.sv | 22 ++
 rtl/vga_bar_ctrl.sv | 135 +++++++++++++
 tb/tb_vga_bar_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bar_pkg.sv
// Shared types and constants for the frame-synchronous VGA bar display path.
package vga_bar_pkg;

  // Default geometry of one set of column sums
  localparam int unsigned NBARS_DFLT   = 6;
  localparam int unsigned SUM_W_DFLT   = 11;
  localparam int unsigned IDX_W_DFLT   = 3;
  localparam int unsigned TIMEOUT_DFLT = 4;

  // Bar controller FSM: gather a set, then wait for vsync to show it
  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } bar_state_e;

  // 640x480 @ 60 Hz timing on a 25 MHz pixel clock (800 x 521 total)
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 29;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_frame_edge.sv
// Registers vsync and flags its falling edge as a one-cycle frame_start pulse.
module vga_frame_edge (
  input  logic dclk,
  input  logic clr_n,
  input  logic vsync,
  output logic frame_start_c
);

  logic vs_d;

  // vsync history; idles high so leaving reset never fakes an edge
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vs_d <= 1'b1;
    end else begin
      vs_d <= vsync;
    end
  end

  assign frame_start_c = vs_d & ~vsync;

endmodule

// File: rtl/vga_bar_ctrl.sv
// Collects per-column sums, thresholds them into a shadow set and swaps the
// set onto the display only at the start of vertical sync.
module vga_bar_ctrl
  import vga_bar_pkg::*;
#(
  parameter int unsigned NBARS          = NBARS_DFLT,
  parameter int unsigned SUM_W          = SUM_W_DFLT,
  parameter int unsigned IDX_W          = IDX_W_DFLT,
  parameter int unsigned TIMEOUT_FRAMES = TIMEOUT_DFLT
) (
  input  logic             dclk,
  input  logic             clr_n,
  input  logic             vsync,
  input  logic [SUM_W-1:0] cfg_thresh,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic [IDX_W-1:0] sum_idx,
  input  logic [SUM_W-1:0] sum_data,
  input  logic             sum_last,
  output logic [NBARS-1:0] bar_on,
  output logic             bar_stale,
  output logic [7:0]       frame_cnt,
  output logic             err_idx
);

  localparam int unsigned STALE_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_FRAMES);

  bar_state_e         state;
  bar_state_e         state_nxt;
  logic               frame_start;
  logic               xfer;
  logic               idx_ok;
  logic               hit;
  logic [NBARS-1:0]   sel;
  logic [NBARS-1:0]   shadow;
  logic [NBARS-1:0]   shadow_nxt;
  logic [NBARS-1:0]   bar_on_nxt;
  logic               bar_stale_nxt;
  logic [STALE_W-1:0] stale_cnt;
  logic [STALE_W-1:0] stale_cnt_nxt;
  logic [7:0]         frame_cnt_nxt;
  logic               err_idx_nxt;

  vga_frame_edge u_frame_edge (
    .dclk          (dclk),
    .clr_n         (clr_n),
    .vsync         (vsync),
    .frame_start_c (frame_start)
  );

  assign xfer   = sum_valid & sum_ready;
  assign idx_ok = 32'(sum_idx) < NBARS;
  assign hit    = sum_data > cfg_thresh;
  assign sel    = NBARS'(1) << sum_idx;

  // State register; ready is registered from the next state so it leaves a flop
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= COLLECT;
      sum_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      sum_ready <= (state_nxt == COLLECT);
    end
  end

  // Next state: a last beat closes the set, the vsync fall releases it
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (xfer && sum_last) state_nxt = PENDING;
      PENDING: if (frame_start)      state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Datapath next values: shadow writes, swap, stale timeout, counters
  always_comb begin
    shadow_nxt    = shadow;
    bar_on_nxt    = bar_on;
    bar_stale_nxt = bar_stale;
    stale_cnt_nxt = stale_cnt;
    err_idx_nxt   = err_idx;
    frame_cnt_nxt = frame_start ? frame_cnt + 8'd1 : frame_cnt;
    case (state)
      COLLECT: begin
        if (xfer) begin
          if (idx_ok) begin
            shadow_nxt = (shadow & ~sel) | (hit ? sel : '0);
          end else begin
            err_idx_nxt = 1'b1;
          end
        end
        // Missed frame: keep the partial set, blank once the timeout is hit
        if (frame_start) begin
          if (stale_cnt != STALE_MAX) stale_cnt_nxt = stale_cnt + STALE_W'(1);
          if (stale_cnt_nxt == STALE_MAX) begin
            bar_on_nxt    = '0;
            bar_stale_nxt = 1'b1;
          end
        end
      end
      PENDING: begin
        if (frame_start) begin
          bar_on_nxt    = shadow;
          shadow_nxt    = '0;
          bar_stale_nxt = 1'b0;
          stale_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Shadow/display registers and status
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      shadow    <= '0;
      bar_on    <= '0;
      bar_stale <= 1'b1;
      stale_cnt <= '0;
      frame_cnt <= 8'd0;
      err_idx   <= 1'b0;
    end else begin
      shadow    <= shadow_nxt;
      bar_on    <= bar_on_nxt;
      bar_stale <= bar_stale_nxt;
      stale_cnt <= stale_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      err_idx   <= err_idx_nxt;
    end
  end

endmodule

// File: tb/tb_vga_bar_ctrl.sv
// Scoreboard bench for vga_bar_ctrl: a frame-level reference model pushes the
// expected display state for every vsync fall, a monitor pops and compares.
module tb_vga_bar_ctrl;
  import vga_bar_pkg::*;

  localparam int unsigned NB     = NBARS_DFLT;
  localparam int unsigned SW     = SUM_W_DFLT;
  localparam int unsigned IW     = IDX_W_DFLT;
  localparam int unsigned TO     = TIMEOUT_DFLT;
  localparam int unsigned FL     = 32;   // short frame period in clocks
  localparam int unsigned BUDGET = 200;  // max cycles to wait for a beat

  typedef struct packed {
    logic [NB-1:0] bar;
    logic          stale;
    logic [7:0]    frames;
    logic          err;
  } frame_rec_t;

  logic          dclk = 1'b0;
  logic          clr_n = 1'b0;
  logic          vsync = 1'b1;
  logic [SW-1:0] cfg_thresh = '0;
  logic          sum_valid = 1'b0;
  logic          sum_ready;
  logic [IW-1:0] sum_idx = '0;
  logic [SW-1:0] sum_data = '0;
  logic          sum_last = 1'b0;
  logic [NB-1:0] bar_on;
  logic          bar_stale;
  logic [7:0]    frame_cnt;
  logic          err_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = FL - 1;

  // Reference model state, kept as plain per-bar bits and integers
  bit            m_shadow [NB];
  logic [NB-1:0] m_bar;
  bit            m_ready, m_stale, m_err, m_vs_prev, m_fs, m_xfer;
  int            m_missed, m_frames;
  frame_rec_t    sb_q [$];
  frame_rec_t    rec;

  vga_bar_ctrl dut (
    .dclk       (dclk),
    .clr_n      (clr_n),
    .vsync      (vsync),
    .cfg_thresh (cfg_thresh),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_idx    (sum_idx),
    .sum_data   (sum_data),
    .sum_last   (sum_last),
    .bar_on     (bar_on),
    .bar_stale  (bar_stale),
    .frame_cnt  (frame_cnt),
    .err_idx    (err_idx)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a set becomes visible at the first vsync fall after it closes
  always @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      foreach (m_shadow[i]) m_shadow[i] = 1'b0;
      m_bar = '0; m_ready = 1'b1; m_stale = 1'b1; m_err = 1'b0;
      m_vs_prev = 1'b1; m_fs = 1'b0; m_xfer = 1'b0;
      m_missed = 0; m_frames = 0;
      sb_q.delete();
    end else begin
      m_fs      = m_vs_prev && !vsync;
      m_vs_prev = vsync;
      m_xfer    = sum_valid && m_ready;
      if (m_fs) begin
        m_frames = (m_frames + 1) % 256;
        if (!m_ready) begin
          for (int i = 0; i < NB; i++) begin
            m_bar[i]    = m_shadow[i];
            m_shadow[i] = 1'b0;
          end
          m_stale = 1'b0; m_missed = 0; m_ready = 1'b1;
        end else begin
          if (m_missed < TO) m_missed++;
          if (m_missed >= TO) begin
            m_bar = '0; m_stale = 1'b1;
          end
        end
      end
      if (m_xfer) begin
        if (int'(sum_idx) < NB) m_shadow[sum_idx] = (sum_data > cfg_thresh);
        else m_err = 1'b1;
        if (sum_last) m_ready = 1'b0;
      end
      if (m_fs) begin
        rec.bar = m_bar; rec.stale = m_stale; rec.frames = 8'(m_frames); rec.err = m_err;
        sb_q.push_back(rec);
      end
    end
  end

  // Monitor: per-cycle handshake/hold checks and per-frame scoreboard pops
  always @(negedge dclk) begin
    frame_rec_t r;
    chk("sum_ready", 32'(sum_ready), 32'(m_ready));
    chk("bar_on_hold", 32'(bar_on), 32'(m_bar));
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk("frame_bar_on", 32'(bar_on), 32'(r.bar));
      chk("frame_bar_stale", 32'(bar_stale), 32'(r.stale));
      chk("frame_cnt", 32'(frame_cnt), 32'(r.frames));
      chk("frame_err_idx", 32'(err_idx), 32'(r.err));
    end
  end

  // One clock: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge dclk);
    #1;
    phase = (phase + 1) % FL;
    vsync = (phase >= 2);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) begin
      do cyc(); while (phase != 1);
    end
  endtask

  task automatic wait_phase(input int p);
    while (phase != p) cyc();
  endtask

  task automatic send_beat(input int idx, input int data, input bit last);
    bit done = 1'b0;
    sum_valid = 1'b1; sum_idx = IW'(idx); sum_data = SW'(data); sum_last = last;
    for (int k = 0; k < BUDGET && !done; k++) begin
      cyc();
      done = m_xfer;
    end
    sum_valid = 1'b0; sum_last = 1'b0;
    chk("beat_accept", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sum_ready"}, 32'(sum_ready), 32'd1);
    chk({tag, "_bar_on"}, 32'(bar_on), 32'd0);
    chk({tag, "_bar_stale"}, 32'(bar_stale), 32'd1);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_err_idx"}, 32'(err_idx), 32'd0);
  endtask

  int d1 [6] = '{5, 1, 3, 0, 2, 9};
  int d2 [6] = '{0, 4, 0, 8, 1, 3};

  initial begin
    cfg_thresh = SW'(2);
    repeat (3) cyc();
    chk_reset_vals("reset");
    clr_n = 1'b1;
    wait_frames(1);

    // Full set, then a beat held through PENDING until the swap
    for (int i = 0; i < 6; i++) send_beat(i, d1[i], i == 5);
    chk("ready_after_last", 32'(sum_ready), 32'd0);
    send_beat(0, 7, 1'b0);
    chk("swap_bar_on", 32'(bar_on), 32'(6'b100101));
    chk("swap_bar_stale", 32'(bar_stale), 32'd0);

    // Four missed frames blank the display; partial shadow survives
    wait_frames(3);
    chk("hold_3_frames", 32'(bar_on), 32'(6'b100101));
    wait_frames(1);
    chk("timeout_bar_on", 32'(bar_on), 32'd0);
    chk("timeout_bar_stale", 32'(bar_stale), 32'd1);
    for (int i = 1; i < 6; i++) send_beat(i, d2[i], i == 5);
    wait_frames(1);
    chk("restore_bar_on", 32'(bar_on), 32'(6'b101011));
    chk("restore_bar_stale", 32'(bar_stale), 32'd0);

    // Last beat coincides with frame_start: swap deferred one frame
    cfg_thresh = SW'(25);
    for (int i = 0; i < 5; i++) send_beat(i, 10 * (i + 1), 1'b0);
    wait_phase(0);
    send_beat(5, 60, 1'b1);
    chk("coincide_bar_on", 32'(bar_on), 32'(6'b101011));
    wait_frames(1);
    chk("coincide_next", 32'(bar_on), 32'(6'b111100));

    // Out-of-range index is flagged and leaves the shadow alone
    send_beat(7, 100, 1'b0);
    chk("err_idx_set", 32'(err_idx), 32'd1);
    send_beat(0, 100, 1'b1);
    wait_frames(1);
    chk("bad_idx_no_write", 32'(bar_on), 32'(6'b000001));
    chk("err_idx_sticky", 32'(err_idx), 32'd1);

    // Reset mid-set, then 256 empty frames to wrap the counter
    wait_phase(8);
    for (int i = 0; i < 3; i++) send_beat(i, 100, 1'b0);
    clr_n = 1'b0;
    cyc();
    chk_reset_vals("midset_reset");
    repeat (2) cyc();
    clr_n = 1'b1;
    wait_frames(256);
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    chk("idle_bar_stale", 32'(bar_stale), 32'd1);
    cfg_thresh = SW'(0);
    for (int i = 3; i < 6; i++) send_beat(i, 1, i == 5);
    wait_frames(1);
    chk("partial_set", 32'(bar_on), 32'(6'b111000));

    // Randomized beats, indices, thresholds and idle gaps
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) cfg_thresh = SW'($urandom_range(0, 2047));
      if ($urandom_range(0, 9) < 6) begin
        send_beat(($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 2047)), $urandom_range(0, 5) == 0);
      end else begin
        cyc();
      end
    end
    wait_frames(2);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
